exception_controller: RTL and testbench

- Consumes `exception_flag` from the exception handle unit in the same stage.
- Sequences the pipeline response to an exception:
  - captures the faulting PC and opcode;
  - flushes and stalls the pipeline;
  - redirects fetch to a fixed handler vector;
  - on return-from-exception, resumes at the instruction after the faulting one.
- A second exception raised inside the handler is fatal and halts the pipeline until reset.

---
 rtl/exception_controller_pkg.sv | 19 +
 rtl/exception_controller_sat_counter.sv | 24 ++
 rtl/exception_controller.sv | 119 +++++++++++
 tb/tb_exception_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/exception_controller_pkg.sv
// Shared definitions for the exception controller slice.
// Holds the FSM state encoding, datapath widths and the default handler vector.
package exc_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned CAUSE_W = 4;

  localparam logic [PC_W-1:0] HANDLER_ADDR_DEFAULT = 16'h0F00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    VECTOR  = 3'd2,
    HANDLER = 3'd3,
    RETURN  = 3'd4,
    FATAL   = 3'd5
  } exc_state_t;

endpackage

// File: rtl/exception_controller_sat_counter.sv
// exc_sat_counter: event counter that sticks at its all-ones value.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high clear
//   inc   - count one event this cycle
//   count - current count, saturates at 2^W-1
module exc_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/exception_controller.sv
// exception_controller: sequences the pipeline response to an exception.
// Captures faulting PC/opcode, flushes and stalls the pipeline, redirects
// fetch to the handler vector, and on eret resumes at the faulting PC + 1.
// A second exception inside the handler latches a fatal halt until reset.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   exception_flag  - exception request from the exception handle unit
//   instruct, pc_in - faulting instruction and its PC
//   eret            - return-from-exception (honoured only in the handler)
//   flush, stall    - pipeline register clear / freeze
//   pc_sel          - fetch takes pc_redirect next cycle
//   pc_redirect     - redirect target
//   epc, cause      - saved faulting PC and opcode
//   in_handler      - handler code executing
//   nested_err      - sticky fatal indicator
//   exc_count       - exceptions accepted, saturating
module exception_controller
  import exc_pkg::*;
#(
  parameter logic [15:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_flag,
  input  logic [15:0] instruct,
  input  logic [15:0] pc_in,
  input  logic        eret,
  output logic        flush,
  output logic        stall,
  output logic        pc_sel,
  output logic [15:0] pc_redirect,
  output logic [15:0] epc,
  output logic [3:0]  cause,
  output logic        in_handler,
  output logic        nested_err,
  output logic [7:0]  exc_count
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  exc_state_t state, state_next;
  logic [3:0] flush_cnt;
  logic       accept;

  // Only the opcode field of the faulting instruction is recorded.
  logic unused_instruct_bits;
  assign unused_instruct_bits = ^instruct[11:0];

  assign accept = (state == IDLE) && exception_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      epc       <= '0;
      cause     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        epc       <= pc_in;
        cause     <= instruct[15:12];
        flush_cnt <= FLUSH_INIT;
      end else if ((state == FLUSH) && (flush_cnt != '0)) begin
        flush_cnt <= flush_cnt - 1'b1;
      end
    end
  end

  // Outputs depend on state and registered epc only, never on inputs.
  always_comb begin
    state_next  = state;
    flush       = 1'b0;
    stall       = 1'b0;
    pc_sel      = 1'b0;
    pc_redirect = '0;
    in_handler  = 1'b0;
    nested_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (exception_flag) state_next = FLUSH;
      end
      FLUSH: begin
        flush = 1'b1;
        stall = 1'b1;
        if (flush_cnt == '0) state_next = VECTOR;
      end
      VECTOR: begin
        pc_sel      = 1'b1;
        pc_redirect = HANDLER_ADDR;
        state_next  = HANDLER;
      end
      HANDLER: begin
        in_handler = 1'b1;
        if (exception_flag) state_next = FATAL;
        else if (eret)      state_next = RETURN;
      end
      RETURN: begin
        pc_sel      = 1'b1;
        flush       = 1'b1;
        pc_redirect = epc + 16'd1;
        state_next  = IDLE;
      end
      FATAL: begin
        stall      = 1'b1;
        nested_err = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  exc_sat_counter #(.W(8)) u_exc_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .count (exc_count)
  );

endmodule

// File: tb/tb_exception_controller.sv
module tb_exception_controller;

  localparam logic [15:0] HADDR = 16'h0F00;
  localparam int          FC    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exception_flag = 1'b0;
  logic [15:0] instruct = '0;
  logic [15:0] pc_in = '0;
  logic        eret = 1'b0;
  logic        flush, stall, pc_sel, in_handler, nested_err;
  logic [15:0] pc_redirect, epc;
  logic [3:0]  cause;
  logic [7:0]  exc_count;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural state recorded per accepted exception.
  logic [15:0] m_epc   = '0;
  logic [3:0]  m_cause = '0;
  int          m_cnt   = 0;

  exception_controller #(.HANDLER_ADDR(HADDR), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .exception_flag(exception_flag), .instruct(instruct),
    .pc_in(pc_in), .eret(eret), .flush(flush), .stall(stall), .pc_sel(pc_sel),
    .pc_redirect(pc_redirect), .epc(epc), .cause(cause), .in_handler(in_handler),
    .nested_err(nested_err), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  // {flush, stall, pc_sel, in_handler, nested_err, pc_redirect}
  function automatic logic [20:0] obs();
    return {flush, stall, pc_sel, in_handler, nested_err, pc_redirect};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_epc = '0;
    m_cause = '0;
    m_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    checks++;
    if (obs() !== 21'h0 || epc !== 16'h0 || cause !== 4'h0 || exc_count !== 8'h0) begin
      errors++;
      $display("FAIL reset_init: got outs=%h epc=%h cause=%h cnt=%0d required all 0",
               obs(), epc, cause, exc_count);
    end
    // Reset asserted while flushing
    exception_flag = 1'b1; pc_in = 16'h1234; instruct = 16'h7000;
    step();
    exception_flag = 1'b0;
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_flush: got flush=%b required 1", flush);
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    checks++;
    if (obs() !== 21'h0 || epc !== 16'h0 || cause !== 4'h0 || exc_count !== 8'h0) begin
      errors++;
      $display("FAIL reset_mid_flush: got outs=%h epc=%h cause=%h cnt=%0d required all 0",
               obs(), epc, cause, exc_count);
    end
  endtask

  // One complete exception/return sequence with full cycle-by-cycle checks.
  task automatic run_seq(input logic [15:0] pc, input logic [15:0] ins,
                         input bit noise, input int hwait, input string tag);
    logic [15:0] ret_pc;
    exception_flag = 1'b1; pc_in = pc; instruct = ins;
    step();
    m_epc = pc;
    m_cause = ins[15:12];
    if (m_cnt < 255) m_cnt++;
    for (int i = 1; i <= FC; i++) begin
      checks++;
      if (obs() !== {5'b11000, 16'h0}) begin
        errors++;
        $display("FAIL %s flush_cycle%0d: got %h required %h", tag, i, obs(), {5'b11000, 16'h0});
      end
      exception_flag = noise;
      if (noise) begin pc_in = 16'($urandom); instruct = 16'($urandom); end
      step();
    end
    checks++;
    if (obs() !== {5'b00100, HADDR}) begin
      errors++;
      $display("FAIL %s vector: got %h required %h", tag, obs(), {5'b00100, HADDR});
    end
    step();
    exception_flag = 1'b0;
    for (int j = 0; j <= hwait; j++) begin
      checks++;
      if (obs() !== {5'b00010, 16'h0} || epc !== m_epc || cause !== m_cause) begin
        errors++;
        $display("FAIL %s handler: got outs=%h epc=%h cause=%h required outs=%h epc=%h cause=%h",
                 tag, obs(), epc, cause, {5'b00010, 16'h0}, m_epc, m_cause);
      end
      pc_in = 16'($urandom);
      if (j < hwait) step();
    end
    eret = 1'b1;
    step();
    eret = 1'b0;
    ret_pc = m_epc + 16'd1;
    checks++;
    if (obs() !== {5'b10100, ret_pc}) begin
      errors++;
      $display("FAIL %s return: got %h required %h", tag, obs(), {5'b10100, ret_pc});
    end
    step();
    checks++;
    if (obs() !== 21'h0 || epc !== m_epc || cause !== m_cause || exc_count !== 8'(m_cnt)) begin
      errors++;
      $display("FAIL %s idle_after: got outs=%h epc=%h cause=%h cnt=%0d required 0 %h %h %0d",
               tag, obs(), epc, cause, exc_count, m_epc, m_cause, m_cnt);
    end
  endtask

  task automatic test_basic();
    run_seq(16'h0042, 16'hB123, 1'b0, 2, "basic");
  endtask

  task automatic test_epc_wrap();
    run_seq(16'hFFFF, 16'h3ABC, 1'b0, 0, "wrap");
  endtask

  task automatic test_ignored_inputs();
    run_seq(16'h2000, 16'h5555, 1'b1, 1, "ignore_flag");
    eret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== 21'h0) begin
        errors++;
        $display("FAIL eret_idle: got %h required 0", obs());
      end
    end
    eret = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_seq(16'h0100, 16'h1111, 1'b0, 0, "b2b_first");
    run_seq(16'h0200, 16'h2222, 1'b0, 0, "b2b_second");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      run_seq(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 4)), "random");
  endtask

  task automatic test_nested();
    exception_flag = 1'b1; pc_in = 16'hABCD; instruct = 16'hC000;
    step();
    exception_flag = 1'b0;
    m_epc = 16'hABCD; m_cause = 4'hC;
    if (m_cnt < 255) m_cnt++;
    for (int i = 0; i <= FC; i++) step();
    checks++;
    if (in_handler !== 1'b1) begin
      errors++;
      $display("FAIL nested_enter: got in_handler=%b required 1", in_handler);
    end
    exception_flag = 1'b1; eret = 1'b1; pc_in = 16'h5A5A; instruct = 16'h9000;
    step();
    eret = 1'b0;
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (obs() !== {5'b01001, 16'h0} || epc !== m_epc || cause !== m_cause ||
          exc_count !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL nested_fatal: got outs=%h epc=%h cause=%h cnt=%0d required %h %h %h %0d",
                 obs(), epc, cause, exc_count, {5'b01001, 16'h0}, m_epc, m_cause, m_cnt);
      end
      exception_flag = 1'($urandom);
      eret = 1'($urandom);
      step();
    end
    exception_flag = 1'b0; eret = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    checks++;
    if (obs() !== 21'h0 || epc !== 16'h0 || exc_count !== 8'h0) begin
      errors++;
      $display("FAIL nested_reset: got outs=%h epc=%h cnt=%0d required 0", obs(), epc, exc_count);
    end
    run_seq(16'h0777, 16'hE000, 1'b0, 0, "after_fatal");
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 256; n++)
      run_seq(16'(n), 16'($urandom), 1'($urandom), 0, "sat");
    checks++;
    if (exc_count !== 8'd255) begin
      errors++;
      $display("FAIL saturation: got %0d required 255", exc_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_epc_wrap();
    test_ignored_inputs();
    test_back_to_back();
    test_random();
    test_nested();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
